count_event_monitor: RTL and testbench
======================================

# count_event_monitor

Downstream consumer of the 8-bit up/down/load counter. Samples the counter value on a strobe and classifies each transition against the previous sample as a wrap-around or a threshold crossing. Qualifying events are pushed into a small show-ahead FIFO, and a host or next stage drains that FIFO over a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- CMP_RESET, 8'h80: threshold register value after reset.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- count_in  input  8  counter value from upstream stage.
- count_vld  input  1  sample strobe; count_in captured when high.
- cmp_val  input  8  new threshold value.
- cmp_load  input  1  load cmp_val into the threshold register.
- clr_ovf  input  1  clear the sticky overflow flag.
- evt_ready  input  1  consumer accepts the head entry.
- evt_valid  output  1  FIFO not empty.
- evt_type  output  2  head event type.
- evt_count  output  8  count_in value that caused the head event.
- ovf  output  1  sticky flag: an event was dropped.
- fifo_level  output  log2(DEPTH)+1  current occupancy.

## Operation
- Registers:
  - prev[7:0]: last sample.
  - primed: a prior sample exists.
  - cmp[7:0]: threshold.
- Sampling:
  - On count_vld, classify (prev, count_in), then prev <= count_in and primed <= 1.
  - When primed=0, the sample produces no event.
- Classification, one event per sample, evaluated in this priority order:
  - WRAP_UP (2'd0): prev==8'hFF and count_in==8'h00.
  - WRAP_DN (2'd1): prev==8'h00 and count_in==8'hFF.
  - CROSS_UP (2'd2): prev<cmp and count_in>=cmp.
  - CROSS_DN (2'd3): prev>=cmp and count_in<cmp.
  - Otherwise no event. Comparisons are unsigned.
  - Load jumps (non-adjacent values) are classified by the same rules, so only crossings are reported.
- Threshold:
  - cmp_load updates cmp at the edge.
  - A sample in the same cycle is compared against the old cmp.
  - Changing cmp never generates an event by itself.
- FIFO push: an event is written {type, count_in}.
  - Push is accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the event is dropped and ovf <= 1.
- FIFO pop: occurs when evt_valid && evt_ready. evt_ready while empty has no effect.
- ovf:
  - Set on a drop; cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, set wins.
- Reset values:
  - Outputs: evt_valid=0, evt_type=0, evt_count=0, ovf=0, fifo_level=0.
  - Internal: prev=0, primed=0, cmp=CMP_RESET, FIFO pointers=0.
- Reset asserted mid-operation discards all FIFO contents and the primed state immediately.

## Timing
- Sample at edge N with the FIFO empty: evt_valid=1 and head outputs valid after edge N (visible in cycle N+1).
- Show-ahead FIFO: evt_type and evt_count are driven from the head entry. They are held stable while evt_valid=1 and evt_ready=0.
- Pop at edge M: the next entry, or evt_valid=0, is visible after edge M.
- Push into an empty FIFO alongside evt_ready=1: no pop occurs that cycle, because evt_valid was 0. The entry appears at the next edge.
- Full throughput is one event per cycle in and one per cycle out.
- fifo_level changes by +1, -1 or 0 per edge. Its range is 0..DEPTH.

## Structure
- Package count_mon_pkg:
  - evt_type_t enum: WRAP_UP, WRAP_DN, CROSS_UP, CROSS_DN.
  - EVT_W=10 constant.
  - evt_t packed struct {evt_type_t type; logic [7:0] count}.
- Sub-module evt_fifo:
  - Synchronous DEPTH-entry show-ahead FIFO of evt_t.
  - Pointer-plus-wrap-bit full/empty detection.
  - Outputs: push_ok, level.
- The top level contains classification, prev/primed/cmp registers and the ovf flag.

## Test plan
- Reset, then samples 8'hFE, 8'hFF, 8'h00 -> exactly one event, {WRAP_UP, 8'h00}. The first sample produces no event.
- cmp=8'h80; samples 8'h7F, 8'h80, 8'h7F -> events CROSS_UP/8'h80, then CROSS_DN/8'h7F, in order.
- Samples 8'h00 then 8'hFF with cmp=8'h80 -> single WRAP_DN/8'hFF; the CROSS_UP is suppressed by priority.
- evt_ready=0, generate 5 events with DEPTH=4 -> fifo_level=4, ovf=1, and the four oldest entries drain intact. clr_ovf -> ovf=0.
- FIFO full, then a simultaneous event push and evt_ready=1 -> no drop, ovf stays 0, fifo_level stays 4.
- Assert reset asynchronously with 3 entries queued -> evt_valid=0, fifo_level=0 and cmp=8'h80 immediately. The next sample after release produces no event.

Source files
------------

// File: rtl/count_mon_pkg.sv
// Shared types for the count event monitor: event codes and the FIFO entry layout.
package count_mon_pkg;

  typedef enum logic [1:0] {
    WRAP_UP  = 2'd0,
    WRAP_DN  = 2'd1,
    CROSS_UP = 2'd2,
    CROSS_DN = 2'd3
  } evt_type_t;

  localparam int EVT_W = 10;

  // 'type' is a reserved word, so the event code field is named etype.
  typedef struct packed {
    evt_type_t  etype;
    logic [7:0] count;
  } evt_t;

endpackage

// File: rtl/evt_fifo.sv
// Show-ahead FIFO of events; full/empty come from pointers carrying an extra wrap bit.
module evt_fifo
  import count_mon_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  evt_t        push_data,
  input  logic        pop_req,
  output logic        evt_valid,
  output evt_t        head,
  output logic        push_ok,
  output logic [AW:0] level
);

  evt_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = pop_req && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign level   = wr_ptr - rd_ptr;

  assign evt_valid = !empty;
  // Head reads as zero while empty so stale storage never shows on the outputs.
  assign head      = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is left unreset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/count_event_monitor.sv
// Samples an 8-bit counter, classifies wrap/threshold transitions and queues them
// for a valid/ready consumer, flagging any event lost to a full queue.
module count_event_monitor
  import count_mon_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] CMP_RESET = 8'h80
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               count_in,
  input  logic                     count_vld,
  input  logic [7:0]               cmp_val,
  input  logic                     cmp_load,
  input  logic                     clr_ovf,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [1:0]               evt_type,
  output logic [7:0]               evt_count,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  logic [7:0] prev;
  logic       primed;
  logic [7:0] cmp;
  logic       hit;
  evt_type_t  etype;
  evt_t       new_evt;
  evt_t       head;
  logic       push;
  logic       push_ok;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    hit   = 1'b1;
    etype = WRAP_UP;
    if (prev == 8'hFF && count_in == 8'h00)      etype = WRAP_UP;
    else if (prev == 8'h00 && count_in == 8'hFF) etype = WRAP_DN;
    else if (prev < cmp && count_in >= cmp)      etype = CROSS_UP;
    else if (prev >= cmp && count_in < cmp)      etype = CROSS_DN;
    else                                         hit   = 1'b0;
  end

  assign push    = count_vld && primed && hit;
  assign new_evt = '{etype: etype, count: count_in};

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev   <= 8'h00;
      primed <= 1'b0;
      cmp    <= CMP_RESET;
      ovf    <= 1'b0;
    end else begin
      if (count_vld) begin
        prev   <= count_in;
        primed <= 1'b1;
      end
      if (cmp_load) cmp <= cmp_val;
      if (push && !push_ok) ovf <= 1'b1;
      else if (clr_ovf)     ovf <= 1'b0;
    end
  end

  evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (new_evt),
    .pop_req   (evt_ready),
    .evt_valid (evt_valid),
    .head      (head),
    .push_ok   (push_ok),
    .level     (fifo_level)
  );

  assign evt_type  = head.etype;
  assign evt_count = head.count;

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: a vector table plus overflow, full-throughput
// and asynchronous-reset sequences.
module tb_count_event_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] count_in;
  logic       count_vld;
  logic [7:0] cmp_val;
  logic       cmp_load;
  logic       clr_ovf;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_type;
  logic [7:0] evt_count;
  logic       ovf;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  count_event_monitor #(.DEPTH(4), .CMP_RESET(8'h80)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .count_vld  (count_vld),
    .cmp_val    (cmp_val),
    .cmp_load   (cmp_load),
    .clr_ovf    (clr_ovf),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_type   (evt_type),
    .evt_count  (evt_count),
    .ovf        (ovf),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] cnt;
    logic       rdy;
    logic       e_valid;
    logic [1:0] e_type;
    logic [7:0] e_count;
    logic [2:0] e_level;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] v);
    count_vld = 1'b1;
    count_in  = v;
    tick();
    count_vld = 1'b0;
  endtask

  task automatic check_head(input string name, input logic [1:0] t, input logic [7:0] c);
    check({name, " valid"}, evt_valid, 1'b1);
    check({name, " type"},  evt_type,  t);
    check({name, " count"}, evt_count, c);
  endtask

  initial begin
    // cmp stays at its reset value 8'h80 and evt_ready=1 throughout the table.
    vecs[0]  = '{1, 8'hFE, 1, 0, 2'd0, 8'h00, 3'd0};  // first sample: no event
    vecs[1]  = '{1, 8'hFF, 1, 0, 2'd0, 8'h00, 3'd0};
    vecs[2]  = '{1, 8'h00, 1, 1, 2'd0, 8'h00, 3'd1};  // WRAP_UP
    vecs[3]  = '{0, 8'h00, 1, 0, 2'd0, 8'h00, 3'd0};  // popped
    vecs[4]  = '{1, 8'h7F, 1, 0, 2'd0, 8'h00, 3'd0};
    vecs[5]  = '{1, 8'h80, 1, 1, 2'd2, 8'h80, 3'd1};  // CROSS_UP
    vecs[6]  = '{1, 8'h7F, 1, 1, 2'd3, 8'h7F, 3'd1};  // CROSS_DN with pop
    vecs[7]  = '{1, 8'h00, 1, 0, 2'd0, 8'h00, 3'd0};
    vecs[8]  = '{1, 8'hFF, 1, 1, 2'd1, 8'hFF, 3'd1};  // WRAP_DN beats CROSS_UP
    vecs[9]  = '{0, 8'h00, 1, 0, 2'd0, 8'h00, 3'd0};
    vecs[10] = '{1, 8'h10, 1, 1, 2'd3, 8'h10, 3'd1};  // load jump FF->10
    vecs[11] = '{1, 8'h20, 1, 0, 2'd0, 8'h00, 3'd0};

    reset = 1'b1; count_in = '0; count_vld = 0; cmp_val = '0; cmp_load = 0;
    clr_ovf = 0; evt_ready = 0;
    #12;
    check("reset evt_valid", evt_valid, 1'b0);
    check("reset evt_type", evt_type, 2'd0);
    check("reset evt_count", evt_count, 8'h00);
    check("reset ovf", ovf, 1'b0);
    check("reset fifo_level", fifo_level, 3'd0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      count_vld = vecs[i].vld;
      count_in  = vecs[i].cnt;
      evt_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d valid", i), evt_valid, vecs[i].e_valid);
      check($sformatf("vec%0d level", i), fifo_level, vecs[i].e_level);
      check($sformatf("vec%0d ovf", i), ovf, 1'b0);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d type", i), evt_type, vecs[i].e_type);
        check($sformatf("vec%0d count", i), evt_count, vecs[i].e_count);
      end
    end
    count_vld = 0;

    // Overflow: five events into a 4-deep queue, prev is 8'h20 here.
    evt_ready = 0;
    sample(8'h90); sample(8'h10); sample(8'hA0); sample(8'h20);
    check("full level", fifo_level, 3'd4);
    check("full no ovf", ovf, 1'b0);
    sample(8'hB0);
    check("drop level", fifo_level, 3'd4);
    check("drop ovf", ovf, 1'b1);
    tick();
    check_head("held head", 2'd2, 8'h90);
    evt_ready = 1;
    check_head("drain0", 2'd2, 8'h90); tick();
    check_head("drain1", 2'd3, 8'h10); tick();
    check_head("drain2", 2'd2, 8'hA0); tick();
    check_head("drain3", 2'd3, 8'h20); tick();
    check("drained valid", evt_valid, 1'b0);
    check("drained level", fifo_level, 3'd0);
    check("ovf sticky", ovf, 1'b1);
    clr_ovf = 1; tick(); clr_ovf = 0;
    check("ovf cleared", ovf, 1'b0);

    // Full queue with simultaneous push and pop; prev is 8'hB0.
    evt_ready = 0;
    sample(8'h10); sample(8'h90); sample(8'h11); sample(8'h91);
    check("refill level", fifo_level, 3'd4);
    evt_ready = 1;
    sample(8'h12);
    evt_ready = 0;
    check("push+pop level", fifo_level, 3'd4);
    check("push+pop ovf", ovf, 1'b0);
    check_head("push+pop head", 2'd2, 8'h90);

    // Leave 3 entries queued and move cmp away from its reset value.
    evt_ready = 1; cmp_load = 1; cmp_val = 8'h40;
    tick();
    evt_ready = 0; cmp_load = 0;
    check("pre-reset level", fifo_level, 3'd3);
    #3 reset = 1'b1;
    #1;
    check("async reset valid", evt_valid, 1'b0);
    check("async reset level", fifo_level, 3'd0);
    check("async reset ovf", ovf, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    sample(8'h90);
    check("unprimed after reset", evt_valid, 1'b0);
    sample(8'h70);
    check_head("cmp restored", 2'd3, 8'h70);
    check("post reset level", fifo_level, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
